lsu_ctrl: RTL and testbench
===========================

LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter DEPTH_LOG2, default 8: log2 of the data-memory depth in 32-bit words (256 words).
REQ-002 clk  in  1  system clock; all state updates on rising edge.
REQ-003 SYS_reset_n  in  1  reset, asynchronous, active-low.
REQ-004 LSU_req  in  1  CPU access request, sampled only in IDLE.
REQ-005 LSU_we  in  1  1 = store, 0 = load.
REQ-006 LSU_size  in  2  00 byte, 01 halfword, 10 word; 11 treated as word.
REQ-007 LSU_unsigned  in  1  1 = zero-extend loads, 0 = sign-extend.
REQ-008 LSU_addr  in  32  byte address.
REQ-009 LSU_wdata  in  32  store data, right-justified.
REQ-010 LSU_busy  out  1  high whenever the FSM is not in IDLE.
REQ-011 LSU_done  out  1  one-cycle completion pulse.
REQ-012 LSU_rdata  out  32  extended load result, valid while LSU_done is high, held until the next load completes.
REQ-013 LSU_misalign  out  1  one-cycle pulse on a rejected misaligned access (see REQ-030).
REQ-014 DMEM_address  out  32  word index {zeros, LSU_addr[DEPTH_LOG2+1:2]}.
REQ-015 DMEM_data_in  out  32  word to write.
REQ-016 DMEM_mem_write  out  1  word write strobe; memory commits on falling clk.
REQ-017 DMEM_mem_read  out  1  read enable.
REQ-018 DMEM_data_out  in  32  combinational read word from memory.

Function
REQ-019 The FSM SHALL have states IDLE, RD, WR, DONE.
REQ-020 In IDLE with LSU_req=1, the block SHALL register addr, we, size, unsigned and wdata.
- Load or sub-word store: go to RD.
- Word store: go to WR.
REQ-021 RD SHALL assert DMEM_mem_read and capture DMEM_data_out at the closing rising edge.
- Load: go to DONE.
- Store: go to WR.
REQ-022 WR SHALL assert DMEM_mem_write for exactly one cycle, then go to DONE.
- Word store: DMEM_data_in = wdata.
- Sub-word store: DMEM_data_in = captured word with only the addressed lanes replaced.
REQ-023 DONE SHALL assert LSU_done for one cycle and return to IDLE; a request in DONE is ignored.
REQ-024 Latency from request edge to LSU_done: load 2 cycles, word store 2 cycles, byte/halfword store 3 cycles.
REQ-025 Lane mapping SHALL be little-endian.
- Byte k = bits [8k+7:8k], k = addr[1:0].
- Halfword lanes selected by addr[1].
REQ-026 Loads SHALL extract the addressed lanes and extend them to 32 bits per LSU_unsigned; word loads pass through unchanged.
REQ-027 Address bits above DEPTH_LOG2+1 SHALL be ignored, so accesses wrap modulo depth.
REQ-028 DMEM_mem_read and DMEM_mem_write SHALL never be high in the same cycle.
REQ-029 Outside RD and WR, DMEM_mem_read and DMEM_mem_write SHALL be 0.

Reset
REQ-030 Asserting SYS_reset_n low SHALL, at any time including mid-operation, immediately force:
- state = IDLE;
- LSU_busy, LSU_done, LSU_misalign, DMEM_mem_write, DMEM_mem_read = 0;
- LSU_rdata and all captured registers = 0.
A pending store SHALL never be committed after reset asserts.
REQ-031 After SYS_reset_n deasserts, the first request SHALL be accepted on the first rising edge.

Configuration
REQ-032 Macro LSU_MISALIGN_TRAP_EN controls misaligned handling.
- Defined: a halfword with addr[0]=1 or a word with addr[1:0]!=0 SHALL skip memory and go directly to DONE, pulsing LSU_misalign with LSU_done; LSU_rdata is unchanged and DMEM is untouched.
- Undefined: the low address bits SHALL be forced to alignment (halfword clears bit 0, word clears bits 1:0), and LSU_misalign SHALL be tied to 0.

Structure
REQ-033 Package lsu_pkg SHALL hold the state enum, the LSU_size codes and the DEPTH_LOG2 default.
REQ-034 Lane merge/extract logic SHALL be a combinational sub-module lsu_lane, instantiated once.

Verification
REQ-035 Word store then load: store 0xDEADBEEF at 0x10, then word load 0x10 -> DMEM word 4 written once; LSU_rdata=0xDEADBEEF after 2 cycles.
REQ-036 Byte RMW: word 4=0x11223344; byte store 0xAA at 0x12 -> word 4=0x11AA3344 after 3 cycles, single write strobe.
REQ-037 Extension: word 4=0x0000F080.
- Signed byte load 0x10 -> 0xFFFFFF80.
- Unsigned halfword load 0x10 -> 0x0000F080.
REQ-038 Wrap: word store 0x5A5A5A5A to 0x400 with DEPTH_LOG2=8 -> DMEM_address=0 and word 0 updated.
REQ-039 Reset mid-RMW: assert SYS_reset_n low while in RD of a byte store -> no DMEM_mem_write, LSU_busy=0 immediately, memory unchanged.
REQ-040 Misalign: word load at 0x13 with LSU_MISALIGN_TRAP_EN -> LSU_misalign and LSU_done high 1 cycle after request, no DMEM_mem_read.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit controller.
package lsu_pkg;

  // Default data-memory depth: 2**8 words of 32 bits.
  localparam int unsigned DefaultDepthLog2 = 8;

  // Access size codes carried on LSU_size; 2'b11 is treated as a word.
  localparam logic [1:0] SizeByte = 2'b00;
  localparam logic [1:0] SizeHalf = 2'b01;
  localparam logic [1:0] SizeWord = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StRd,
    StWr,
    StDone
  } lsu_state_e;

  // Both 2'b10 and 2'b11 select a full word.
  function automatic logic is_word(input logic [1:0] size);
    return size[1];
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Little-endian lane logic: extracts and extends load data, and merges store
// data into the previously read word for sub-word stores. Purely combinational.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] rd_word,
  input  logic [31:0] base_word,
  input  logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic [31:0] st_word
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Select the addressed lanes and build the load result / merged store word.
  always_comb begin
    ld_byte = rd_word[{addr_lo, 3'b000} +: 8];
    ld_half = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];
    ld_data = rd_word;
    st_word = wdata;
    if (size == SizeByte) begin
      ld_data = {{24{ld_byte[7] & ~is_unsigned}}, ld_byte};
      st_word = base_word;
      st_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
    end else if (size == SizeHalf) begin
      ld_data = {{16{ld_half[15] & ~is_unsigned}}, ld_half};
      st_word = base_word;
      if (addr_lo[1]) begin
        st_word[31:16] = wdata[15:0];
      end else begin
        st_word[15:0] = wdata[15:0];
      end
    end
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: sequences single-word data-memory accesses,
// doing read-modify-write for byte/halfword stores.
// Build option LSU_MISALIGN_TRAP_EN: when defined, misaligned halfword/word
// requests are rejected with LSU_misalign; otherwise addresses are aligned down.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = DefaultDepthLog2
) (
  input  logic        clk,
  input  logic        SYS_reset_n,
  input  logic        LSU_req,
  input  logic        LSU_we,
  input  logic [1:0]  LSU_size,
  input  logic        LSU_unsigned,
  input  logic [31:0] LSU_addr,
  input  logic [31:0] LSU_wdata,
  output logic        LSU_busy,
  output logic        LSU_done,
  output logic [31:0] LSU_rdata,
  output logic        LSU_misalign,
  output logic [31:0] DMEM_address,
  output logic [31:0] DMEM_data_in,
  output logic        DMEM_mem_write,
  output logic        DMEM_mem_read,
  input  logic [31:0] DMEM_data_out
);

  // Byte-address bits that reach memory; higher bits wrap.
  localparam int unsigned AddrW = DEPTH_LOG2 + 2;

  lsu_state_e state_q, state_d;

  logic [AddrW-1:0] addr_q, addr_d;
  logic             we_q;
  logic [1:0]       size_q;
  logic             uns_q;
  logic [31:0]      wdata_q;
  logic [31:0]      word_q;
  logic [31:0]      rdata_q;
  logic [31:0]      ld_data;
  logic [31:0]      st_word;
  logic             accept;

  logic unused_addr;
  assign unused_addr = ^LSU_addr[31:AddrW];

  assign accept = (state_q == StIdle) && LSU_req;

`ifdef LSU_MISALIGN_TRAP_EN
  logic req_mis;
  logic mis_q;

  // Flag halfwords on odd bytes and words off a word boundary.
  always_comb begin
    req_mis = ((LSU_size == SizeHalf) && LSU_addr[0]) ||
              (is_word(LSU_size) && (LSU_addr[1:0] != 2'b00));
    addr_d  = LSU_addr[AddrW-1:0];
  end

  // Misalign pulse coincides with the DONE cycle that follows the rejection.
  always_ff @(posedge clk or negedge SYS_reset_n) begin
    if (!SYS_reset_n) begin
      mis_q <= 1'b0;
    end else begin
      mis_q <= accept && req_mis;
    end
  end

  assign LSU_misalign = mis_q;
`else
  // Force natural alignment by clearing the low address bits.
  always_comb begin
    addr_d = LSU_addr[AddrW-1:0];
    if (LSU_size == SizeHalf) begin
      addr_d[0] = 1'b0;
    end else if (is_word(LSU_size)) begin
      addr_d[1:0] = 2'b00;
    end
  end

  assign LSU_misalign = 1'b0;
`endif

  // Next-state decode; word stores skip the read phase.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (LSU_req) begin
`ifdef LSU_MISALIGN_TRAP_EN
          if (req_mis) begin
            state_d = StDone;
          end else if (LSU_we && is_word(LSU_size)) begin
            state_d = StWr;
          end else begin
            state_d = StRd;
          end
`else
          if (LSU_we && is_word(LSU_size)) begin
            state_d = StWr;
          end else begin
            state_d = StRd;
          end
`endif
        end
      end
      StRd:    state_d = we_q ? StWr : StDone;
      StWr:    state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge SYS_reset_n) begin
    if (!SYS_reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Request capture in IDLE and read-word capture at the end of RD.
  always_ff @(posedge clk or negedge SYS_reset_n) begin
    if (!SYS_reset_n) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      word_q  <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        addr_q  <= addr_d;
        we_q    <= LSU_we;
        size_q  <= LSU_size;
        uns_q   <= LSU_unsigned;
        wdata_q <= LSU_wdata;
      end
      if (state_q == StRd) begin
        word_q <= DMEM_data_out;
        if (!we_q) begin
          rdata_q <= ld_data;
        end
      end
    end
  end

  lsu_lane u_lane (
    .addr_lo     (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .rd_word     (DMEM_data_out),
    .base_word   (word_q),
    .wdata       (wdata_q),
    .ld_data     (ld_data),
    .st_word     (st_word)
  );

  assign LSU_busy       = (state_q != StIdle);
  assign LSU_done       = (state_q == StDone);
  assign LSU_rdata      = rdata_q;
  assign DMEM_address   = {{(32 - DEPTH_LOG2){1'b0}}, addr_q[AddrW-1:2]};
  assign DMEM_data_in   = st_word;
  assign DMEM_mem_read  = (state_q == StRd);
  assign DMEM_mem_write = (state_q == StWr);

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: a behavioural memory model predicts each
// access; a monitor checks every completion against the queued prediction.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        SYS_reset_n;
  logic        LSU_req, LSU_we, LSU_unsigned;
  logic [1:0]  LSU_size;
  logic [31:0] LSU_addr, LSU_wdata;
  logic        LSU_busy, LSU_done, LSU_misalign;
  logic [31:0] LSU_rdata;
  logic [31:0] DMEM_address, DMEM_data_in, DMEM_data_out;
  logic        DMEM_mem_write, DMEM_mem_read;

  always #5 clk = ~clk;

  lsu_ctrl #(.DEPTH_LOG2(8)) dut (
    .clk            (clk),
    .SYS_reset_n    (SYS_reset_n),
    .LSU_req        (LSU_req),
    .LSU_we         (LSU_we),
    .LSU_size       (LSU_size),
    .LSU_unsigned   (LSU_unsigned),
    .LSU_addr       (LSU_addr),
    .LSU_wdata      (LSU_wdata),
    .LSU_busy       (LSU_busy),
    .LSU_done       (LSU_done),
    .LSU_rdata      (LSU_rdata),
    .LSU_misalign   (LSU_misalign),
    .DMEM_address   (DMEM_address),
    .DMEM_data_in   (DMEM_data_in),
    .DMEM_mem_write (DMEM_mem_write),
    .DMEM_mem_read  (DMEM_mem_read),
    .DMEM_data_out  (DMEM_data_out)
  );

  // Memory seen by the DUT: commits on falling clk, reads combinationally.
  logic [31:0] mem [256];
  bit          mem_init = 1'b0;
  always @(negedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'(i) * 32'h9E37_79B9;
      mem_init <= 1'b1;
    end else if (DMEM_mem_write) begin
      mem[DMEM_address[7:0]] <= DMEM_data_in;
    end
  end
  assign DMEM_data_out = mem[DMEM_address[7:0]];

  // Reference model state.
  logic [31:0] ref_mem [256];
  logic [31:0] last_rdata;

  typedef struct {
    int          lat;
    logic [31:0] rdata;
    logic        mis;
    int          n_wr;
    int          n_rd;
    logic [31:0] wr_idx;
    logic [31:0] wr_word;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Predict one access from the architectural rules and queue the result.
  task automatic predict(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
    exp_t        e;
    logic [31:0] a, w, v, mask;
    int          sh;
    logic        mis;
    a   = addr;
    mis = (size == 2'b01 && a[0]) || (size[1] && a[1:0] != 2'b00);
    e.mis = 1'b0; e.n_wr = 0; e.n_rd = 0; e.wr_idx = 0; e.wr_word = 0;
`ifdef LSU_MISALIGN_TRAP_EN
    if (mis) begin
      e.lat = 1; e.mis = 1'b1; e.rdata = last_rdata;
      sb.push_back(e);
      return;
    end
`else
    if (mis) a = (size == 2'b01) ? (a & ~32'd1) : (a & ~32'd3);
`endif
    w = ref_mem[a[9:2]];
    if (size == 2'b00) begin
      sh = 8 * int'(a[1:0]); mask = 32'hFF;
    end else if (size == 2'b01) begin
      sh = 16 * int'(a[1]); mask = 32'hFFFF;
    end else begin
      sh = 0; mask = 32'hFFFF_FFFF;
    end
    if (!we) begin
      v = (w >> sh) & mask;
      if (!uns && size == 2'b00 && v[7])  v = v | 32'hFFFF_FF00;
      if (!uns && size == 2'b01 && v[15]) v = v | 32'hFFFF_0000;
      last_rdata = v;
      e.lat = 2; e.n_rd = 1;
    end else begin
      v = (w & ~(mask << sh)) | ((wdata & mask) << sh);
      ref_mem[a[9:2]] = v;
      e.lat = size[1] ? 2 : 3; e.n_rd = size[1] ? 0 : 1; e.n_wr = 1;
      e.wr_idx = {24'd0, a[9:2]}; e.wr_word = v;
    end
    e.rdata = last_rdata;
    sb.push_back(e);
  endtask

  // Called at a falling edge with the DUT idle; returns at a falling edge, idle.
  task automatic do_op(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    int n;
    predict(we, size, uns, addr, wdata);
    LSU_req = 1'b1; LSU_we = we; LSU_size = size; LSU_unsigned = uns;
    LSU_addr = addr; LSU_wdata = wdata;
    @(negedge clk);
    LSU_req = 1'b0;
    n = 0;
    while (LSU_busy && n < 10) begin
      // A request during DONE must be ignored.
      if (LSU_done && $urandom_range(0, 1) == 1) begin
        LSU_req = 1'b1; LSU_we = 1'($urandom); LSU_size = 2'($urandom);
        LSU_addr = $urandom; LSU_wdata = $urandom;
      end
      @(negedge clk);
      LSU_req = 1'b0;
      n++;
    end
    if (n >= 10) check("op_timeout", 32'd1, 32'd0);
  endtask

  // Monitor: accumulates per-operation activity, checks it at each LSU_done.
  int          busy_cnt = 0, wr_cnt = 0, rd_cnt = 0, overlap = 0, stray = 0;
  logic [31:0] wr_addr = 0, wr_data = 0;
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!SYS_reset_n) begin
        busy_cnt = 0; wr_cnt = 0; rd_cnt = 0;
        continue;
      end
      if (DMEM_mem_read && DMEM_mem_write) overlap++;
      if (!LSU_busy && (DMEM_mem_read || DMEM_mem_write || LSU_done)) stray++;
      if (LSU_misalign && !LSU_done) stray++;
      if (LSU_busy) busy_cnt++;
      if (DMEM_mem_read) rd_cnt++;
      if (DMEM_mem_write) begin
        wr_cnt++; wr_addr = DMEM_address; wr_data = DMEM_data_in;
      end
      if (LSU_done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("latency", busy_cnt, e.lat);
          check("rdata", LSU_rdata, e.rdata);
          check("misalign", {31'd0, LSU_misalign}, {31'd0, e.mis});
          check("write_strobes", wr_cnt, e.n_wr);
          check("read_strobes", rd_cnt, e.n_rd);
          check("rw_overlap", overlap, 0);
          if (e.n_wr != 0) begin
            check("write_address", wr_addr, e.wr_idx);
            check("write_data", wr_data, e.wr_word);
          end
        end
        busy_cnt = 0; wr_cnt = 0; rd_cnt = 0; overlap = 0;
      end
    end
  end

  initial begin
    logic [31:0] a;
    int          bad_words;
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'(i) * 32'h9E37_79B9;
    last_rdata = 32'd0;
    SYS_reset_n = 1'b0; LSU_req = 1'b0; LSU_we = 1'b0; LSU_size = 2'b00;
    LSU_unsigned = 1'b0; LSU_addr = 32'd0; LSU_wdata = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, LSU_busy}, 32'd0);
    check("rst_done", {31'd0, LSU_done}, 32'd0);
    check("rst_misalign", {31'd0, LSU_misalign}, 32'd0);
    check("rst_strobes", {30'd0, DMEM_mem_read, DMEM_mem_write}, 32'd0);
    check("rst_rdata", LSU_rdata, 32'd0);
    check("rst_address", DMEM_address, 32'd0);
    SYS_reset_n = 1'b1;

    // Word store then load; byte RMW; extension; wrap; misaligned load.
    do_op(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
    do_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    do_op(1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_3344);
    do_op(1'b1, 2'b00, 1'b0, 32'h12, 32'h0000_00AA);
    do_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    do_op(1'b1, 2'b10, 1'b0, 32'h10, 32'h0000_F080);
    do_op(1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
    do_op(1'b0, 2'b01, 1'b1, 32'h10, 32'h0);
    do_op(1'b1, 2'b10, 1'b0, 32'h400, 32'h5A5A_5A5A);
    do_op(1'b0, 2'b11, 1'b0, 32'h0, 32'h0);
    do_op(1'b0, 2'b10, 1'b0, 32'h13, 32'h0);
    do_op(1'b0, 2'b01, 1'b0, 32'h11, 32'h0);

    // Reset while a byte store sits in its read phase.
    do_op(1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_3344);
    LSU_req = 1'b1; LSU_we = 1'b1; LSU_size = 2'b00; LSU_addr = 32'h12;
    LSU_wdata = 32'hAA;
    @(posedge clk);
    #2;
    LSU_req = 1'b0;
    check("rmw_rd_busy", {31'd0, LSU_busy}, 32'd1);
    check("rmw_rd_read", {31'd0, DMEM_mem_read}, 32'd1);
    SYS_reset_n = 1'b0;
    #1;
    check("midrst_busy", {31'd0, LSU_busy}, 32'd0);
    check("midrst_strobes", {30'd0, DMEM_mem_read, DMEM_mem_write}, 32'd0);
    check("midrst_rdata", LSU_rdata, 32'd0);
    last_rdata = 32'd0;
    @(negedge clk);
    @(negedge clk);
    SYS_reset_n = 1'b1;
    do_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);

    // Randomized traffic, half of it concentrated on a few words.
    for (int i = 0; i < 300; i++) begin
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a = a & 32'hF000_003F;
      do_op(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    check("stray_activity", stray, 0);
    bad_words = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad_words++;
    check("memory_image", bad_words, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard stop so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
